serial_demux_collector: RTL and testbench



---
 rtl/serial_demux_collector_pkg.sv | 11 +
 rtl/serial_demux_collector_if.sv | 27 ++
 rtl/serial_demux_collector_lane_counter.sv | 34 +++
 rtl/serial_demux_collector.sv | 99 +++++++++
 tb/tb_serial_demux_collector.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/serial_demux_collector_pkg.sv
// Shared types and defaults for the serial 1:N demultiplexing collector.
package demux_pkg;

    localparam int LANES_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } demux_state_e;

endpackage

// File: rtl/serial_demux_collector_if.sv
// Stream-side and word-side signals of the collector bundled as one interface.
interface serial_demux_collector_if
    import demux_pkg::*;
#(
    parameter int LANES = LANES_DEF
);
    localparam int SEL_W = $clog2(LANES);

    logic             sync;
    logic             din;
    logic             din_valid;
    logic [LANES-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [SEL_W-1:0] lane_sel;
    logic             overrun;

    modport master (
        output sync, din, din_valid, dout_ready,
        input  dout, dout_valid, lane_sel, overrun
    );

    modport slave (
        input  sync, din, din_valid, dout_ready,
        output dout, dout_valid, lane_sel, overrun
    );
endinterface

// File: rtl/serial_demux_collector_lane_counter.sv
// Lane select counter: clear (optionally straight to 1), increment, terminal count.
module lane_counter #(
    parameter int LANES = 4,
    parameter int SEL_W = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [SEL_W-1:0] count,
    output logic             tc
);
    localparam logic [SEL_W-1:0] ZERO = SEL_W'(0);
    localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES - 1);

    logic [SEL_W-1:0] count_r;

    // Clear with a coincident increment lands on 1 so the first bit of a frame is counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= ZERO;
        end else if (clr) begin
            count_r <= inc ? ONE : ZERO;
        end else if (inc) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign tc    = (count_r == LAST);
endmodule

// File: rtl/serial_demux_collector.sv
// Steers a serial bit stream into LANES lanes and presents each full word on a
// registered valid/ready output with a sticky overrun flag.
module serial_demux_collector
    import demux_pkg::*;
#(
    parameter int LANES = LANES_DEF
) (
    input logic                     clk,
    input logic                     rst,
    serial_demux_collector_if.slave bus
);
    localparam int SEL_W = $clog2(LANES);

    demux_state_e     state_r;
    demux_state_e     state_s;
    logic [LANES-1:0] shadow_r;
    logic [LANES-1:0] shadow_s;
    logic [LANES-1:0] word_s;
    logic [LANES-1:0] dout_r;
    logic             dout_valid_r;
    logic             overrun_r;
    logic [SEL_W-1:0] lane_sel_s;
    logic             tc_s;
    logic             inc_s;
    logic             complete_s;

    lane_counter #(.LANES(LANES), .SEL_W(SEL_W)) u_lane_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.sync),
        .inc   (inc_s),
        .count (lane_sel_s),
        .tc    (tc_s)
    );

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, lane advance, shadow update and word-complete detection.
    always_comb begin
        state_s    = state_r;
        shadow_s   = shadow_r;
        inc_s      = bus.din_valid && (bus.sync || (state_r == FILL));
        complete_s = bus.din_valid && !bus.sync && (state_r == FILL) && tc_s;
        word_s     = shadow_r;
        word_s[LANES-1] = bus.din;
        case (state_r)
            IDLE:    state_s = bus.sync ? FILL : IDLE;
            FILL:    state_s = FILL;
            default: state_s = IDLE;
        endcase
        if (bus.sync) begin
            shadow_s    = {LANES{1'b0}};
            shadow_s[0] = bus.din_valid & bus.din;
        end else if ((state_r == FILL) && bus.din_valid) begin
            shadow_s[lane_sel_s] = bus.din;
        end else begin
            shadow_s = shadow_r;
        end
    end

    // Shadow word holding the partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r <= {LANES{1'b0}};
        end else begin
            shadow_r <= shadow_s;
        end
    end

    // Output word handshake; a full word arriving while the old one is stuck is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r       <= {LANES{1'b0}};
            dout_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else if (complete_s && (!dout_valid_r || bus.dout_ready)) begin
            dout_r       <= word_s;
            dout_valid_r <= 1'b1;
        end else if (complete_s) begin
            overrun_r    <= 1'b1;
        end else if (dout_valid_r && bus.dout_ready) begin
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= dout_valid_r;
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.overrun    = overrun_r;
    assign bus.lane_sel   = lane_sel_s;
endmodule

// File: tb/tb_serial_demux_collector.sv
// Directed and randomized checks of serial_demux_collector against a queue-based model.
module tb_serial_demux_collector;
    localparam int LANES = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    bit   chk_en;

    // reference model state
    bit             m_fill;
    bit             m_bits[$];
    logic [LANES-1:0] m_dout;
    logic           m_valid;
    logic           m_ovr;

    serial_demux_collector_if #(.LANES(LANES)) bus ();

    serial_demux_collector #(.LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bits collected since the last sync; a word is the first LANES of them.
    task automatic model_step(input bit rs, input bit s, input bit d, input bit dv, input bit r);
        bit complete;
        logic [LANES-1:0] w;
        complete = 1'b0;
        w = '0;
        if (rs) begin
            m_fill = 1'b0;
            m_bits.delete();
            m_dout = '0;
            m_valid = 1'b0;
            m_ovr = 1'b0;
            return;
        end
        if (s) begin
            m_bits.delete();
            m_fill = 1'b1;
            if (dv) m_bits.push_back(d);
        end else if (m_fill && dv) begin
            m_bits.push_back(d);
            if (m_bits.size() == LANES) begin
                complete = 1'b1;
                for (int i = 0; i < LANES; i++) w[i] = m_bits[i];
                m_bits.delete();
            end
        end
        if (complete) begin
            if (!m_valid || r) begin
                m_dout = w;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic cyc(input bit s, input bit d, input bit dv, input bit r, input bit rs);
        rst = rs;
        bus.sync = s;
        bus.din = d;
        bus.din_valid = dv;
        bus.dout_ready = r;
        @(posedge clk);
        model_step(rs, s, d, dv, r);
        chk_en = 1'b1;
        #1;
    endtask

    task automatic send_word(input logic [LANES-1:0] w, input bit r);
        for (int i = 0; i < LANES; i++) cyc(1'b0, w[i], 1'b1, r, 1'b0);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dout", 32'(bus.dout), 32'(m_dout));
            chk("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
            chk("overrun", 32'(bus.overrun), 32'(m_ovr));
            chk("lane_sel", 32'(bus.lane_sel), 32'(m_bits.size()));
        end
    end

    initial begin
        logic [LANES-1:0] lanes_seen;
        n_vec = 0;
        n_err = 0;
        chk_en = 1'b0;
        m_fill = 1'b0;
        m_dout = '0;
        m_valid = 1'b0;
        m_ovr = 1'b0;

        // 1: reset, then data without sync is ignored
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_valid", 32'(bus.dout_valid), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("idle_valid", 32'(bus.dout_valid), 32'd0);
        chk("idle_lane", 32'(bus.lane_sel), 32'd0);
        chk("idle_dout", 32'(bus.dout), 32'h0);

        // 2: sync then 1,0,1,1 with ready high
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t2_pre_valid", 32'(bus.dout_valid), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t2_dout", 32'(bus.dout), 32'hd);
        chk("t2_valid", 32'(bus.dout_valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_valid_drop", 32'(bus.dout_valid), 32'd0);
        chk("t2_ovr", 32'(bus.overrun), 32'd0);

        // 3: sync coincident with first bit
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        lanes_seen[0] = bus.lane_sel[0];
        chk("t3_lane1", 32'(bus.lane_sel), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_lane2", 32'(bus.lane_sel), 32'd2);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_lane3", 32'(bus.lane_sel), 32'd3);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_lane0", 32'(bus.lane_sel), 32'd0);
        chk("t3_dout", 32'(bus.dout), 32'h1);

        // 4: two frames with ready low -> overrun, first word kept
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(4'b0110, 1'b0);
        send_word(4'b1001, 1'b0);
        chk("t4_dout", 32'(bus.dout), 32'h6);
        chk("t4_ovr", 32'(bus.overrun), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_valid", 32'(bus.dout_valid), 32'd0);

        // 5: accept and reload in the same cycle
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(4'b0011, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_old", 32'(bus.dout), 32'h3);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t5_dout", 32'(bus.dout), 32'ha);
        chk("t5_valid", 32'(bus.dout_valid), 32'd1);
        chk("t5_ovr", 32'(bus.overrun), 32'd0);

        // 6: partial frame discarded by sync, then reset mid-frame
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(4'b1111, 1'b1);
        chk("t6_dout", 32'(bus.dout), 32'hf);
        chk("t6_ovr", 32'(bus.overrun), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_rst_dout", 32'(bus.dout), 32'h0);
        chk("t6_rst_valid", 32'(bus.dout_valid), 32'd0);
        chk("t6_rst_lane", 32'(bus.lane_sel), 32'd0);
        chk("t6_rst_ovr", 32'(bus.overrun), 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 15) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                1'($urandom), ($urandom_range(0, 299) == 0));
        end

        chk_en = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
